servo_pwm_driver: RTL

- Downstream stage of the PID controller. Consumes the 0..120 degree rotation command and drives one hobby-servo PWM pin.
- Produces a fixed-period frame (default 20 ms at 100 MHz) with a high pulse mapped linearly from MIN_CYC to MAX_CYC.
- Applies a per-frame slew limit so PID output steps cannot slam the servo.
- Updates the angle only at frame boundaries, so the pin never shows a truncated or glitched pulse.

---
 rtl/servo_pkg.sv | 19 +
 rtl/servo_slew_limiter.sv | 21 ++
 rtl/servo_pwm_driver.sv | 101 ++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared constants, FSM state type and the angle-to-pulse-width mapping
// used by the servo PWM driver (and its bench model).
package servo_pkg;

    localparam int DEG_MAX    = 120;
    localparam int DEG_CENTER = 60;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    // Linear map 0..DEG_MAX -> min_c..max_c, truncating, 64-bit intermediate.
    function automatic longint unsigned width_cyc(input logic [7:0] ang,
                                                  input longint unsigned min_c,
                                                  input longint unsigned max_c);
        longint unsigned a;
        a = {56'd0, ang};
        return min_c + (a * (max_c - min_c)) / 64'(DEG_MAX);
    endfunction

endpackage

// File: rtl/servo_slew_limiter.sv
// Combinational next-angle: moves cur toward target by at most SLEW_DEG.
module servo_slew_limiter #(
    parameter int SLEW_DEG = 4
) (
    input  logic [7:0] cur,
    input  logic [7:0] target,
    output logic [7:0] nxt
);

    logic       up;
    logic [7:0] diff;
    logic [7:0] step;

    always_comb begin
        up   = target > cur;
        diff = up ? target - cur : cur - target;
        step = (int'(diff) > SLEW_DEG) ? 8'(SLEW_DEG) : diff;
        nxt  = up ? cur + step : cur - step;
    end

endmodule

// File: rtl/servo_pwm_driver.sv
// Hobby-servo PWM driver: fixed-period frames, pulse width from a slew-limited
// angle that only changes at frame boundaries.
module servo_pwm_driver
    import servo_pkg::*;
#(
    parameter int FRAME_CYC = 2000000,
    parameter int MIN_CYC   = 100000,
    parameter int MAX_CYC   = 200000,
    parameter int SLEW_DEG  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] angle_in,
    input  logic       angle_valid,
    output logic       pwm_out,
    output logic [7:0] cur_angle,
    output logic       frame_tick,
    output logic       clamp_err
);

    localparam int            CW       = $clog2(FRAME_CYC);
    localparam logic [CW-1:0] LAST     = CW'(FRAME_CYC - 1);
    localparam logic [CW-1:0] W_CENTER = CW'(width_cyc(8'(DEG_CENTER), 64'(MIN_CYC), 64'(MAX_CYC)));

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wid;
    logic [7:0]    target;
    logic [7:0]    nxt_angle;
    logic          boundary;

    servo_slew_limiter #(.SLEW_DEG(SLEW_DEG)) u_slew (
        .cur    (cur_angle),
        .target (target),
        .nxt    (nxt_angle)
    );

    // A frame starts either from IDLE or by wrapping at the end of LOW.
    assign boundary = en && (state == IDLE || (state == LOW && cnt == LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target    <= 8'(DEG_CENTER);
            clamp_err <= 1'b0;
        end else begin
            clamp_err <= angle_valid && (angle_in > 8'(DEG_MAX));
            if (angle_valid)
                target <= (angle_in > 8'(DEG_MAX)) ? 8'(DEG_MAX) : angle_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wid        <= W_CENTER;
            cur_angle  <= 8'(DEG_CENTER);
            pwm_out    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (boundary) begin
                state     <= HIGH;
                cnt       <= '0;
                cur_angle <= nxt_angle;
                wid       <= CW'(width_cyc(nxt_angle, 64'(MIN_CYC), 64'(MAX_CYC)));
                pwm_out   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        cnt     <= '0;
                        pwm_out <= 1'b0;
                    end
                    HIGH: begin
                        cnt <= cnt + CW'(1);
                        if (cnt == wid - CW'(1)) begin
                            state   <= LOW;
                            pwm_out <= 1'b0;
                        end
                    end
                    LOW: begin
                        // End of frame with en low: park in IDLE, no tick.
                        if (cnt == LAST) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            pwm_out <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        pwm_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
